// File: rtl/skid_buffer_generic_if.sv
// Valid/ready handshake bundle for skid_buffer_generic.
// master drives the upstream/downstream side, slave is the buffer.
interface skid_buffer_generic_if #(
    parameter int BITWIDTH = 16,
    parameter int NINPUTS  = 1
) ();

    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [BITWIDTH-1:0] in_data [NINPUTS];
    logic                out_valid;
    logic                out_ready;
    logic [BITWIDTH-1:0] out_data [NINPUTS];
    logic [1:0]          count;

    modport master (
        output flush,
        output in_valid,
        input  in_ready,
        output in_data,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  count
    );

    modport slave (
        input  flush,
        input  in_valid,
        output in_ready,
        input  in_data,
        output out_valid,
        input  out_ready,
        output out_data,
        output count
    );

endinterface

// File: rtl/skid_buffer_generic.sv
// Two-entry elastic pipeline register, NINPUTS lanes per bundle.
// in_ready comes straight from the state flop to cut the ready path.
module skid_buffer_generic #(
    parameter int BITWIDTH = 16,
    parameter int NINPUTS  = 1
) (
    input logic                 clk,
    input logic                 rst,
    skid_buffer_generic_if.slave sif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [BITWIDTH-1:0] main [NINPUTS];
    logic [BITWIDTH-1:0] skid [NINPUTS];

    logic       in_ready;
    logic       out_valid;
    logic [1:0] count;
    logic       in_xfer;
    logic       out_xfer;
    logic       load_main_in;
    logic       load_main_skid;
    logic       load_skid;

    // Handshake flags and occupancy decoded from the state flop only
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        count     = 2'd0;
        unique case (state)
            EMPTY: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
                count     = 2'd0;
            end
            ONE: begin
                in_ready  = 1'b1;
                out_valid = 1'b1;
                count     = 2'd1;
            end
            FULL: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                count     = 2'd2;
            end
            default: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
                count     = 2'd0;
            end
        endcase
    end

    assign in_xfer  = sif.in_valid & in_ready;
    assign out_xfer = out_valid & sif.out_ready;

    // Next state and register load selects
    always_comb begin
        state_n        = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state)
            EMPTY: begin
                if (in_xfer) begin
                    load_main_in = 1'b1;
                    state_n      = ONE;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    load_main_in = 1'b1;
                end else if (in_xfer) begin
                    load_skid = 1'b1;
                    state_n   = FULL;
                end else if (out_xfer) begin
                    state_n = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    load_main_skid = 1'b1;
                    state_n        = ONE;
                end
            end
            default: begin
                state_n = EMPTY;
            end
        endcase
    end

    // State register; reset and flush both squash to EMPTY
    always_ff @(posedge clk) begin
        if (rst || sif.flush) begin
            state <= EMPTY;
        end else begin
            state <= state_n;
        end
    end

    // Main register: head of the buffer, cleared on squash
    always_ff @(posedge clk) begin
        if (rst || sif.flush) begin
            for (int i = 0; i < NINPUTS; i++) begin
                main[i] <= '0;
            end
        end else if (load_main_in) begin
            for (int i = 0; i < NINPUTS; i++) begin
                main[i] <= sif.in_data[i];
            end
        end else if (load_main_skid) begin
            for (int i = 0; i < NINPUTS; i++) begin
                main[i] <= skid[i];
            end
        end
    end

    // Skid register: catches the bundle accepted while the head stalls
    always_ff @(posedge clk) begin
        if (rst || sif.flush) begin
            for (int i = 0; i < NINPUTS; i++) begin
                skid[i] <= '0;
            end
        end else if (load_skid) begin
            for (int i = 0; i < NINPUTS; i++) begin
                skid[i] <= sif.in_data[i];
            end
        end
    end

    assign sif.in_ready  = in_ready;
    assign sif.out_valid = out_valid;
    assign sif.count     = count;
    assign sif.out_data  = main;

endmodule

// File: tb/tb_skid_buffer_generic.sv
// Bench for skid_buffer_generic: directed cases on a 1x16 instance,
// randomized traffic on a 4x32 instance against a queue model.
module tb_skid_buffer_generic;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    skid_buffer_generic_if #(.BITWIDTH(16), .NINPUTS(1)) a_if ();
    skid_buffer_generic_if #(.BITWIDTH(32), .NINPUTS(4)) b_if ();

    skid_buffer_generic #(.BITWIDTH(16), .NINPUTS(1)) u_a (
        .clk (clk),
        .rst (rst),
        .sif (a_if.slave)
    );

    skid_buffer_generic #(.BITWIDTH(32), .NINPUTS(4)) u_b (
        .clk (clk),
        .rst (rst),
        .sif (b_if.slave)
    );

    // Single comparison point: counts and reports
    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle on instance A, then step past the edge
    task automatic a_step(input logic iv, input logic [15:0] d,
                          input logic ordy, input logic fl,
                          input logic rs);
        a_if.in_valid   = iv;
        a_if.in_data[0] = d;
        a_if.out_ready  = ordy;
        a_if.flush      = fl;
        rst             = rs;
        @(posedge clk);
        #1;
    endtask

    // Expected occupancy/flags/head on instance A
    task automatic a_expect(input string tag, input int cnt,
                            input logic chk_d, input logic [15:0] d);
        check({tag, "_count"}, 64'(a_if.count), 64'(cnt));
        check({tag, "_ovalid"}, 64'(a_if.out_valid), 64'(cnt != 0));
        check({tag, "_iready"}, 64'(a_if.in_ready), 64'(cnt != 2));
        if (chk_d) begin
            check({tag, "_data"}, 64'(a_if.out_data[0]), 64'(d));
        end
    endtask

    logic [127:0] q[$];
    logic [127:0] cur;
    logic         have;
    logic         acc_in;
    logic         acc_out;
    logic         fl_now;
    int           seq;

    initial begin
        a_if.in_valid   = 1'b0;
        a_if.in_data[0] = '0;
        a_if.out_ready  = 1'b0;
        a_if.flush      = 1'b0;
        b_if.in_valid   = 1'b0;
        b_if.out_ready  = 1'b0;
        b_if.flush      = 1'b0;
        for (int j = 0; j < 4; j++) begin
            b_if.in_data[j] = '0;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset for two cycles
        a_step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        a_step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        a_expect("reset", 0, 1'b1, 16'h0);

        // Full-throughput stream
        for (int k = 1; k <= 8; k++) begin
            a_step(1'b1, 16'(k), 1'b1, 1'b0, 1'b0);
            a_expect("stream", 1, 1'b1, 16'(k));
        end
        a_step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        a_expect("stream_end", 0, 1'b0, 16'h0);

        // Backpressure fill, held third push, then drain
        a_step(1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0);
        a_expect("bp1", 1, 1'b1, 16'hAAAA);
        a_step(1'b1, 16'hBBBB, 1'b0, 1'b0, 1'b0);
        a_expect("bp2", 2, 1'b1, 16'hAAAA);
        a_step(1'b1, 16'hCCCC, 1'b0, 1'b0, 1'b0);
        a_expect("bp_hold", 2, 1'b1, 16'hAAAA);
        a_step(1'b1, 16'hCCCC, 1'b1, 1'b0, 1'b0);
        a_expect("bp_pop1", 1, 1'b1, 16'hBBBB);
        a_step(1'b1, 16'hCCCC, 1'b1, 1'b0, 1'b0);
        a_expect("bp_pop2", 1, 1'b1, 16'hCCCC);
        a_step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        a_expect("bp_empty", 0, 1'b0, 16'h0);

        // Push and pop together while ONE
        a_step(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0);
        a_expect("sim_hold", 1, 1'b1, 16'h1111);
        a_step(1'b1, 16'h2222, 1'b1, 1'b0, 1'b0);
        a_expect("sim_swap", 1, 1'b1, 16'h2222);
        a_step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        a_expect("sim_empty", 0, 1'b0, 16'h0);

        // Flush while FULL with concurrent push and pop
        a_step(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
        a_step(1'b1, 16'h0020, 1'b0, 1'b0, 1'b0);
        a_expect("fl_full", 2, 1'b1, 16'h0010);
        a_step(1'b1, 16'h0030, 1'b1, 1'b1, 1'b0);
        a_expect("flush", 0, 1'b1, 16'h0);
        a_step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        a_expect("fl_after", 0, 1'b1, 16'h0);

        // Reset wins over a pending push while FULL
        a_step(1'b1, 16'h0040, 1'b0, 1'b0, 1'b0);
        a_step(1'b1, 16'h0050, 1'b0, 1'b0, 1'b0);
        a_expect("rst_full", 2, 1'b1, 16'h0040);
        a_step(1'b1, 16'h0060, 1'b0, 1'b0, 1'b1);
        a_expect("rst_mid", 0, 1'b1, 16'h0);
        a_step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic on the 4x32 instance
        q.delete();
        have = 1'b0;
        seq  = 0;
        cur  = '0;
        check("b_start_count", 64'(b_if.count), 64'(0));
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (!have) begin
                for (int j = 0; j < 4; j++) begin
                    cur[j*32 +: 32] = 32'hDEAD0000 + 32'(seq << 4) + 32'(j);
                end
                have = 1'b1;
            end
            b_if.in_valid  = ($urandom_range(0, 3) != 0);
            b_if.out_ready = 1'($urandom_range(0, 1));
            fl_now         = ($urandom_range(0, 99) == 0);
            b_if.flush     = fl_now;
            for (int j = 0; j < 4; j++) begin
                b_if.in_data[j] = b_if.in_valid ? cur[j*32 +: 32] : 'x;
            end

            check("b_count", 64'(b_if.count), 64'(q.size()));
            check("inv_max", 64'(b_if.count <= 2'd2), 64'(1));
            check("inv_rdy", 64'(b_if.in_ready), 64'(b_if.count != 2'd2));
            check("inv_vld", 64'(b_if.out_valid), 64'(b_if.count != 2'd0));
            if (q.size() > 0) begin
                for (int j = 0; j < 4; j++) begin
                    check($sformatf("b_lane%0d", j),
                          64'(b_if.out_data[j]), 64'(q[0][j*32 +: 32]));
                end
            end

            acc_in  = b_if.in_valid && (q.size() < 2);
            acc_out = (q.size() > 0) && b_if.out_ready;
            @(posedge clk);
            #1;
            if (fl_now) begin
                q.delete();
            end else begin
                if (acc_out) begin
                    void'(q.pop_front());
                end
                if (acc_in) begin
                    q.push_back(cur);
                end
            end
            if (acc_in) begin
                have = 1'b0;
                seq++;
            end
        end
        check("b_end_count", 64'(b_if.count), 64'(q.size()));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/skid_buffer_generic.md
Name: skid_buffer_generic

Overview:
- Two-entry elastic pipeline register with a valid/ready handshake on both sides.
- Carries NINPUTS lanes of BITWIDTH bits as one bundle.
- Sits between OOO pipeline stages (e.g. decode->rename, rename->dispatch) wherever the downstream stage can stall.
- Breaks the combinational ready path: in_ready is driven only from a flop.

Parameters:
- BITWIDTH, 16, width of each lane.
- NINPUTS, 1, number of lanes per bundle (unpacked array dimension).

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous discard of all buffered bundles (pipeline squash).
- in_valid  input  1  upstream bundle valid.
- in_ready  output  1  buffer can accept a bundle this cycle.
- in_data  input  [BITWIDTH-1:0] x [NINPUTS-1:0]  upstream bundle.
- out_valid  output  1  head bundle valid.
- out_ready  input  1  downstream accepts the head this cycle.
- out_data  output  [BITWIDTH-1:0] x [NINPUTS-1:0]  head bundle.
- count  output  2  occupancy, 0..2.

Behaviour:
- Transfer rules:
  - In-transfer = in_valid & in_ready.
  - Out-transfer = out_valid & out_ready.
  - Both are evaluated at posedge clk.
- Storage: main register (drives out_data), skid register, 2-bit state.
- States and outputs:
  - EMPTY: count=0, out_valid=0, in_ready=1.
  - ONE: count=1, out_valid=1, in_ready=1.
  - FULL: count=2, out_valid=1, in_ready=0.
- in_ready, out_valid and count are decoded from the state flop only, never from in_valid or out_ready.
- out_data = main register, combinationally. It is meaningful only when out_valid=1.
- Transitions (when rst=0 and flush=0):
  - EMPTY, in-transfer: main<=in_data; go to ONE.
  - ONE, in- and out-transfer together: main<=in_data; stay in ONE (full throughput, 1 bundle/cycle).
  - ONE, in-transfer only: skid<=in_data; go to FULL.
  - ONE, out-transfer only: go to EMPTY.
  - FULL, out-transfer: main<=skid; go to ONE. No in-transfer is possible because in_ready=0.
  - Otherwise: hold all state.
- Latency:
  - A bundle accepted in EMPTY appears on out_data/out_valid the next cycle.
  - Ordering is strictly FIFO; no bundle is ever dropped or duplicated.
- Flush:
  - At posedge with flush=1: state<=EMPTY; main and skid <= all zeros.
  - Any same-cycle in-transfer or out-transfer is discarded. The upstream handshake still completes, and the bundle is lost by design.
- Reset:
  - rst=1 at posedge gives the same result as flush: state=EMPTY, count=0, out_valid=0, in_ready=1, out_data=0.
  - rst has priority over flush and over any handshake.
  - Reset asserted mid-stream drops both entries.
- in_data is sampled only on in-transfer. X on in_data while in_valid=0 must not propagate into state.
- Invariants (assert in the bench):
  - count never exceeds 2.
  - in_ready == (count != 2).
  - out_valid == (count != 0).

Test Plan:
- Reset then stream: assert rst for 2 cycles, then push 0x0001..0x0008 with out_ready=1 every cycle -> out_valid rises 1 cycle after the first push; outputs 0x0001..0x0008 in order, one per cycle; count stays 1; in_ready stays 1.
- Backpressure fill: out_ready=0; push 0xAAAA then 0xBBBB -> count=2, in_ready=0, out_data=0xAAAA; a third push 0xCCCC is held upstream. Then out_ready=1 -> drains 0xAAAA, 0xBBBB, 0xCCCC in order.
- Simultaneous in/out in ONE: hold 0x1111, then push 0x2222 in the same cycle as the pop -> next cycle out_data=0x2222, count=1, skid unused.
- Flush while FULL with concurrent push: state FULL (0x10, 0x20), out_ready=1, flush=1 -> next cycle count=0, out_valid=0, out_data=0, in_ready=1; 0x10 is not counted as delivered.
- Reset mid-operation and priority: FULL, then rst=1 and flush=0 with in_valid=1 -> next cycle count=0, out_data=0.
- NINPUTS=4, BITWIDTH=32: lanes 0xDEAD0000+i and random out_ready for 1000 cycles -> scoreboard matches every lane in order; invariants hold throughout.
